// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and dataMemory: forwards loads, drains stores in idle port cycles.
// Optional build macro STORE_COALESCE_EN merges a store into the youngest entry when the addresses match.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module store_buffer #(
   parameter int unsigned WORD_SIZE = `WORD_SIZE,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 st_valid_i,
   input  logic [WORD_SIZE-1:0] st_addr_i,
   input  logic [WORD_SIZE-1:0] st_data_i,
   output logic                 st_ready_o,
   input  logic                 ld_valid_i,
   input  logic [WORD_SIZE-1:0] ld_addr_i,
   output logic [WORD_SIZE-1:0] ld_data_o,
   output logic                 ld_fwd_o,
   input  logic                 fence_i,
   output logic                 fence_done_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic                 mem_we_o,
   output logic [WORD_SIZE-1:0] mem_a_o,
   output logic [WORD_SIZE-1:0] mem_wd_o,
   input  logic [WORD_SIZE-1:0] mem_rd_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FENCE = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       head_q, tail_q;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [WORD_SIZE-1:0]   addr_q [DEPTH];
   logic [WORD_SIZE-1:0]   data_q [DEPTH];

   logic                   push, pop, alloc, coalesce;
   logic                   fwd;
   logic [WORD_SIZE-1:0]   fwd_data;
   logic [PTR_W-1:0]       idx;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign st_ready_o = !full_o && (state_q != FENCE);

   // Port arbitration: a pending load owns the port, otherwise the head drains.
   assign pop      = !ld_valid_i && !empty_o;
   assign mem_we_o = pop;
   assign mem_a_o  = pop ? addr_q[head_q] : ld_addr_i;
   assign mem_wd_o = data_q[head_q];

   assign push = st_valid_i && st_ready_o;

`ifdef STORE_COALESCE_EN
   logic [PTR_W-1:0] young_idx;
   assign young_idx = tail_q - PTR_W'(1);
   // The youngest entry cannot be merged into if it is the head leaving this cycle.
   assign coalesce  = push && !empty_o && (st_addr_i == addr_q[young_idx]) &&
                      !(pop && (count_q == CNT_W'(1)));
`else
   assign coalesce  = 1'b0;
`endif

   assign alloc   = push && !coalesce;
   assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

   // Scan oldest to youngest so the last hit is the youngest matching store.
   always_comb begin
      fwd      = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (addr_q[idx] == ld_addr_i)) begin
            fwd      = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   assign ld_fwd_o  = fwd;
   assign ld_data_o = fwd ? fwd_data : mem_rd_i;

   always_comb begin
      state_d      = state_q;
      fence_done_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fence_i) begin
               if (empty_o) fence_done_o = 1'b1;
               else         state_d      = FENCE;
            end
         end
         FENCE: begin
            if (count_d == '0) state_d = DONE;
         end
         DONE: begin
            fence_done_o = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (pop) head_q <= head_q + PTR_W'(1);
         if (alloc) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
            tail_q         <= tail_q + PTR_W'(1);
         end
         if (coalesce) data_q[tail_q - PTR_W'(1)] <= st_data_i;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural dataMemory; build-dependent rows follow STORE_COALESCE_EN.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid, ld_valid, fence;
   logic [31:0] st_addr, st_data, ld_addr;
   logic        st_ready, ld_fwd, fence_done, empty, full, mem_we;
   logic [31:0] ld_data, mem_a, mem_wd, mem_rd;
   logic [31:0] dmem [1024];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk_i(clk), .rst_ni(rst_n),
      .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_ready_o(st_ready),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_o(ld_data), .ld_fwd_o(ld_fwd),
      .fence_i(fence), .fence_done_o(fence_done), .empty_o(empty), .full_o(full),
      .mem_we_o(mem_we), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
   );

   // dataMemory model: combinational read, write on the rising edge.
   assign mem_rd = dmem[mem_a[9:0]];
   initial begin
      for (int i = 0; i < 1024; i++) dmem[i] = 32'hDEAD_0000 + 32'(i);
      forever begin
         @(posedge clk);
         if (mem_we) dmem[mem_a[9:0]] = mem_wd;
      end
   end

   typedef struct {
      logic        sv; logic [31:0] sa; logic [31:0] sd;
      logic        lv; logic [31:0] la; logic        fe;
      logic        rdy; logic fwd; logic [31:0] ldd;
      logic        emp; logic full; logic we; logic [31:0] a; logic [31:0] wd; logic fd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic lv, input logic [31:0] la, input logic fe,
                              input logic rdy, input logic fwd, input logic [31:0] ldd,
                              input logic emp, input logic fl, input logic we,
                              input logic [31:0] a, input logic [31:0] wd, input logic fd);
      vec_t t;
      t.sv = sv; t.sa = sa; t.sd = sd; t.lv = lv; t.la = la; t.fe = fe;
      t.rdy = rdy; t.fwd = fwd; t.ldd = ldd; t.emp = emp; t.full = fl;
      t.we = we; t.a = a; t.wd = wd; t.fd = fd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Drive one cycle of inputs, check the settled outputs, then cross the clock edge.
   task automatic step(input vec_t t, input int n);
      st_valid = t.sv; st_addr = t.sa; st_data = t.sd;
      ld_valid = t.lv; ld_addr = t.la; fence = t.fe;
      #2;
      chk($sformatf("v%0d.st_ready", n),   32'(st_ready),   32'(t.rdy));
      chk($sformatf("v%0d.ld_fwd", n),     32'(ld_fwd),     32'(t.fwd));
      chk($sformatf("v%0d.empty", n),      32'(empty),      32'(t.emp));
      chk($sformatf("v%0d.full", n),       32'(full),       32'(t.full));
      chk($sformatf("v%0d.mem_we", n),     32'(mem_we),     32'(t.we));
      chk($sformatf("v%0d.mem_a", n),      mem_a,           t.a);
      chk($sformatf("v%0d.fence_done", n), 32'(fence_done), 32'(t.fd));
      if (t.lv) chk($sformatf("v%0d.ld_data", n), ld_data, t.ldd);
      if (t.we) chk($sformatf("v%0d.mem_wd", n), mem_wd, t.wd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single store drains in the next idle cycle.
      vecs.push_back(v(1,'h100,'hFFFF0000, 0,0,0, 1,0,0,            1,0,0,'h000,0,0));
      vecs.push_back(v(0,0,0,              0,0,0, 1,0,0,            0,0,1,'h100,'hFFFF0000,0));
      vecs.push_back(v(0,0,0,         1,'h100,0, 1,0,'hFFFF0000,    1,0,0,'h100,0,0));
      // Fill to full behind a blocking load, forward, then drain in order.
      vecs.push_back(v(1,'h200,'h11,  1,'h300,0, 1,0,'hDEAD0300,    1,0,0,'h300,0,0));
      vecs.push_back(v(1,'h201,'h22,  1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(1,'h202,'h33,  1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(1,'h203,'h44,  1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(1,'h2FF,'h99,  1,'h300,0, 0,0,'hDEAD0300,    0,1,0,'h300,0,0));
      vecs.push_back(v(0,0,0,         1,'h202,0, 0,1,'h33,          0,1,0,'h202,0,0));
      vecs.push_back(v(1,'h2FE,'h77,  0,0,0,     0,0,0,             0,1,1,'h200,'h11,0));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h201,'h22,0));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h202,'h33,0));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h203,'h44,0));
      vecs.push_back(v(0,0,0,         1,'h203,0, 1,0,'h44,          1,0,0,'h203,0,0));
      vecs.push_back(v(0,0,0,         1,'h2FE,0, 1,0,'hDEAD02FE,    1,0,0,'h2FE,0,0));
      vecs.push_back(v(0,0,0,         1,'h2FF,0, 1,0,'hDEAD02FF,    1,0,0,'h2FF,0,0));
      // Two stores to one address: youngest forwarded and last in memory.
      vecs.push_back(v(1,'h200,'h1,   1,'h300,0, 1,0,'hDEAD0300,    1,0,0,'h300,0,0));
      vecs.push_back(v(1,'h200,'h2,   1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(0,0,0,         1,'h200,0, 1,1,'h2,           0,0,0,'h200,0,0));
`ifdef STORE_COALESCE_EN
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h200,'h2,0));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             1,0,0,'h000,0,0));
`else
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h200,'h1,0));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h200,'h2,0));
`endif
      vecs.push_back(v(0,0,0,         1,'h200,0, 1,0,'h2,           1,0,0,'h200,0,0));
      // Fence over two entries: stores refused while draining, one done pulse.
      vecs.push_back(v(1,'h210,'hA1,  1,'h300,0, 1,0,'hDEAD0300,    1,0,0,'h300,0,0));
      vecs.push_back(v(1,'h211,'hA2,  1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(0,0,0,         0,0,1,     1,0,0,             0,0,1,'h210,'hA1,0));
      vecs.push_back(v(1,'h2FD,'h55,  0,0,1,     0,0,0,             0,0,1,'h211,'hA2,0));
      vecs.push_back(v(0,0,0,         0,0,1,     1,0,0,             1,0,0,'h000,0,1));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             1,0,0,'h000,0,0));
      vecs.push_back(v(0,0,0,         1,'h2FD,0, 1,0,'hDEAD02FD,    1,0,0,'h2FD,0,0));
      // Fence on an empty buffer completes immediately.
      vecs.push_back(v(0,0,0,         0,0,1,     1,0,0,             1,0,0,'h000,0,1));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             1,0,0,'h000,0,0));
      // Three entries queued for the reset-mid-drain sequence.
      vecs.push_back(v(1,'h220,'hB1,  1,'h300,0, 1,0,'hDEAD0300,    1,0,0,'h300,0,0));
      vecs.push_back(v(1,'h221,'hB2,  1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(1,'h222,'hB3,  1,'h300,0, 1,0,'hDEAD0300,    0,0,0,'h300,0,0));
      vecs.push_back(v(0,0,0,         0,0,0,     1,0,0,             0,0,1,'h220,'hB1,0));

      st_valid = 0; st_addr = 0; st_data = 0; ld_valid = 0; ld_addr = 0; fence = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("reset.st_ready",   32'(st_ready),   32'd1);
      chk("reset.empty",      32'(empty),      32'd1);
      chk("reset.full",       32'(full),       32'd0);
      chk("reset.mem_we",     32'(mem_we),     32'd0);
      chk("reset.fence_done", 32'(fence_done), 32'd0);
      chk("reset.ld_fwd",     32'(ld_fwd),     32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Reset lands while the second of three entries is on the port.
      st_valid = 0; ld_valid = 0; fence = 0; ld_addr = 0;
      #1;
      chk("rstmid.pre_we", 32'(mem_we), 32'd1);
      chk("rstmid.pre_a",  mem_a,       32'h221);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid.mem_we",   32'(mem_we),   32'd0);
      chk("rstmid.empty",    32'(empty),    32'd1);
      chk("rstmid.st_ready", 32'(st_ready), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(v(0,0,0, 1,'h220,0, 1,0,'hB1,       1,0,0,'h220,0,0), 100);
      step(v(0,0,0, 1,'h221,0, 1,0,'hDEAD0221, 1,0,0,'h221,0,0), 101);
      step(v(0,0,0, 1,'h222,0, 1,0,'hDEAD0222, 1,0,0,'h222,0,0), 102);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
